// File: rtl/nn_pkg.sv
// Types and constants shared by the neuron datapath blocks and the BRAM wrapper.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_t;

  localparam int WORD_LEN_DEF  = 32;
  localparam int FRAC_BITS_DEF = 16;

  // Wide enough that a full evaluation of NUM_INPUTS products plus bias cannot overflow.
  function automatic int acc_len(input int word_len, input int num_inputs);
    return 2 * word_len + $clog2(num_inputs) + 1;
  endfunction

endpackage

// File: rtl/fixed_point_relu_sat.sv
// Rescales a wide fixed-point accumulator to WORD_LEN, clamps at the positive limit
// and applies ReLU. Purely combinational.
module fixed_point_relu_sat #(
  parameter int ACC_LEN   = 69,
  parameter int WORD_LEN  = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic signed [ACC_LEN-1:0]  acc_i,
  output logic        [WORD_LEN-1:0] result_o
);

  function automatic logic [WORD_LEN-1:0] relu_sat(input logic signed [ACC_LEN-1:0] a);
    logic signed [ACC_LEN-1:0] s;
    s = a >>> FRAC_BITS;
    if (s[ACC_LEN-1]) begin
      return '0;
    end else if (|s[ACC_LEN-2:WORD_LEN-1]) begin
      // Non-negative but above the largest positive word.
      return {1'b0, {(WORD_LEN-1){1'b1}}};
    end else begin
      return s[WORD_LEN-1:0];
    end
  endfunction

  assign result_o = relu_sat(acc_i);

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron MAC: walks the activation/weight BRAM, accumulates
// x*w on top of the bias, then offers ReLU(saturated sum) on a valid/ready port.
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int WORD_LEN   = WORD_LEN_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic signed [WORD_LEN-1:0]     bias_i,
  output logic                           busy_o,
  output logic                           mem_ena_o,
  output logic [$clog2(NUM_INPUTS)-1:0]  rd_addr_1_o,
  output logic [$clog2(NUM_INPUTS)-1:0]  rd_addr_2_o,
  input  logic signed [WORD_LEN-1:0]     mem_data_1_i,
  input  logic signed [WORD_LEN-1:0]     mem_data_2_i,
  output logic [WORD_LEN-1:0]            result_o,
  output logic                           valid_o,
  input  logic                           ready_i
);

  localparam int AW      = $clog2(NUM_INPUTS);
  localparam int ACC_LEN = acc_len(WORD_LEN, NUM_INPUTS);
  localparam int PW      = 2 * WORD_LEN;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);

  mac_state_t                 state_q;
  logic [AW-1:0]              addr_q;
  logic                       rv_q;
  logic                       mem_ena_q;
  logic                       valid_q;
  logic                       busy_q;
  logic [WORD_LEN-1:0]        result_q;
  logic signed [ACC_LEN-1:0]  acc_q;
  logic signed [ACC_LEN-1:0]  acc_d;
  logic signed [ACC_LEN-1:0]  bias_ext;
  logic signed [PW-1:0]       prod;
  logic [WORD_LEN-1:0]        relu_w;
  logic                       accept;

  assign accept   = start_i & ((state_q == IDLE) | ((state_q == OUT) & ready_i));
  assign bias_ext = $signed({{(ACC_LEN-WORD_LEN){bias_i[WORD_LEN-1]}}, bias_i}) <<< FRAC_BITS;
  assign prod     = mem_data_1_i * mem_data_2_i;

  // Gated by the read-valid pipe so idle-BRAM zeros never reach the sum.
  always_comb begin
    acc_d = acc_q;
    if (rv_q) begin
      acc_d = acc_q + $signed({{(ACC_LEN-PW){prod[PW-1]}}, prod});
    end
  end

  // Fed with acc_d so the product landing in DRAIN is already included.
  fixed_point_relu_sat #(
    .ACC_LEN  (ACC_LEN),
    .WORD_LEN (WORD_LEN),
    .FRAC_BITS(FRAC_BITS)
  ) u_relu_sat (
    .acc_i   (acc_d),
    .result_o(relu_w)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rv_q      <= 1'b0;
      mem_ena_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
    end else begin
      rv_q  <= (state_q == RUN);
      acc_q <= accept ? bias_ext : acc_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RUN;
            addr_q    <= '0;
            mem_ena_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (addr_q == LAST_ADDR) begin
            state_q   <= DRAIN;
            mem_ena_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q  <= OUT;
          result_q <= relu_w;
          valid_q  <= 1'b1;
        end
        OUT: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (start_i) begin
              state_q   <= RUN;
              addr_q    <= '0;
              mem_ena_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_ena_q <= 1'b0;
          valid_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign mem_ena_o   = mem_ena_q;
  assign rd_addr_1_o = addr_q;
  assign rd_addr_2_o = addr_q;
  assign result_o    = result_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a behavioural BRAM and a result scoreboard.
module tb_neuron_mac_seq;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int AW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                ready = 1'b0;
  logic signed [W-1:0] bias = '0;
  logic                busy, mem_ena, valid;
  logic [AW-1:0]       addr1, addr2;
  logic signed [W-1:0] md1 = '0, md2 = '0;
  logic [W-1:0]        result;

  logic signed [W-1:0] xm [N];
  logic signed [W-1:0] wm [N];
  logic [W-1:0]        sb [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac_seq #(.NUM_INPUTS(N), .WORD_LEN(W), .FRAC_BITS(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bias_i(bias),
    .busy_o(busy), .mem_ena_o(mem_ena), .rd_addr_1_o(addr1), .rd_addr_2_o(addr2),
    .mem_data_1_i(md1), .mem_data_2_i(md2), .result_o(result),
    .valid_o(valid), .ready_i(ready)
  );

  // BRAM: one-cycle read latency, drives zeros while disabled.
  always @(posedge clk) begin
    if (mem_ena) begin
      md1 <= xm[addr1];
      md2 <= wm[addr2];
    end else begin
      md1 <= '0;
      md2 <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic signed [W-1:0] b);
    logic signed [127:0] acc;
    logic signed [127:0] s;
    logic signed [63:0]  p;
    acc = {{96{b[W-1]}}, b};
    acc = acc <<< 16;
    for (int k = 0; k < N; k++) begin
      p   = xm[k] * wm[k];
      acc = acc + p;
    end
    s = acc >>> 16;
    if (s < 0) return '0;
    if (s > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    return s[W-1:0];
  endfunction

  task automatic fill(input logic signed [W-1:0] xv, input logic signed [W-1:0] wv);
    for (int k = 0; k < N; k++) begin
      xm[k] = xv;
      wm[k] = wv;
    end
  endtask

  task automatic do_start(input logic signed [W-1:0] b);
    bias  = b;
    start = 1'b1;
    sb.push_back(model(b));
    tick();
    start = 1'b0;
  endtask

  task automatic take_result(input string tag);
    logic [W-1:0] exp;
    int n;
    n = 0;
    while (!valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, valid, 1'b1);
    exp = 'x;
    if (sb.size() > 0) exp = sb.pop_front();
    chk(tag, result, exp);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk({tag, "_idle"}, {busy, valid, mem_ena}, 3'b000);
  endtask

  int rises;

  initial begin
    fill(32'sh0001_0000, 32'sh0000_8000);
    tick();
    tick();
    chk("rst_outputs", {busy, mem_ena, valid, addr1, addr2}, '0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;
    tick();

    // Nominal: 5 * (1.0 * 0.5) = 2.5, with exact cycle timing
    do_start(32'sh0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("nom_ena%0d", k), {busy, mem_ena}, 2'b11);
      chk($sformatf("nom_addr%0d", k), {addr1, addr2}, {AW'(k), AW'(k)});
      tick();
    end
    chk("nom_drain", {busy, mem_ena, valid}, 3'b100);
    tick();
    chk("nom_valid_at7", valid, 1'b1);
    chk("nom_const", result, 32'h0002_8000);
    take_result("nom_result");
    consume("nom");

    // Negative sum clamps to zero
    fill(32'sh0001_0000, 32'shFFFF_0000);
    do_start(32'sh0002_0000);
    take_result("neg_result");
    chk("neg_const", result, 32'h0);
    consume("neg");

    // Bias only
    fill(32'sh0001_0000, 32'sh0);
    do_start(32'sh0003_0000);
    take_result("bias_result");
    chk("bias_const", result, 32'h0003_0000);
    consume("bias");

    // Positive saturation
    fill(32'sh7FFF_0000, 32'sh7FFF_0000);
    do_start(32'sh0);
    take_result("sat_result");
    chk("sat_const", result, 32'h7FFF_FFFF);
    consume("sat");

    // Backpressure then back-to-back restart with a new bias
    fill(32'sh0001_0000, 32'sh0000_8000);
    do_start(32'sh0001_0000);
    take_result("bp_first");
    chk("bp_first_const", result, 32'h0003_8000);
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      tick();
      chk($sformatf("bp_hold%0d", c), {valid, busy, mem_ena, result}, {3'b110, 32'h0003_8000});
    end
    fill(32'sh0002_0000, 32'sh0001_0000);
    ready = 1'b1;
    do_start(32'shFFFF_0000);
    ready = 1'b0;
    chk("b2b_run", {busy, mem_ena, valid, addr1}, {3'b110, AW'(0)});
    take_result("b2b_result");
    chk("b2b_const", result, 32'h0009_0000);
    consume("b2b");

    // Reset in the middle of RUN
    fill(32'sh0001_0000, 32'sh0000_8000);
    bias  = 32'sh0005_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_addr2", {mem_ena, addr1}, {1'b1, AW'(2)});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {busy, mem_ena, valid}, 3'b000);
    rises = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid || busy) rises++;
    end
    chk("mid_no_spurious", rises, 0);
    do_start(32'sh0);
    take_result("mid_rerun");
    chk("mid_rerun_const", result, 32'h0002_8000);
    consume("mid");

    // Idle with BRAM zeros: nothing must happen
    rises = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid || busy || mem_ena) rises++;
    end
    chk("idle_quiet", rises, 0);

    // -0.25 floors negative -> 0
    fill(32'sh0, 32'sh0);
    xm[0] = 32'sh0001_0000;
    wm[0] = 32'shFFFF_C000;
    do_start(32'sh0);
    take_result("quarter_neg");
    chk("quarter_neg_const", result, 32'h0);
    consume("qn");

    // One raw LSB of product truncates to 0
    fill(32'sh0, 32'sh0);
    xm[3] = 32'sh1;
    wm[3] = 32'sh1;
    do_start(32'sh0);
    take_result("lsb");
    chk("lsb_const", result, 32'h0);
    consume("lsb");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
